spi_frame_transmitter: RTL
==========================

# spi_frame_transmitter

Serial transmit end of the SPI link: accepts one parallel `size`-bit frame via a start/ready handshake and shifts it out MSB-first on `mosi`, with a generated serial clock `sclk` and an active-low frame select `ssN`. It is the counterpart of the serial-to-parallel receive shift register, which captures one bit per `sclk` rising edge while selected and flags a full frame after `size` bits. It sits on the master side of the router's SPI interface, between the frame builder and the pins.

## Interface
- `size`, 25: frame length in bits; legal values are 2 or more.
- `divider`, 4: system clocks per serial bit; must be even and at least 2. `half` = `divider`/2.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high; returns the block to IDLE immediately.
- `clear`  in  1  synchronous abort; has priority over `start`.
- `start`  in  1  request to send; accepted only when `ready`=1.
- `dataIn`  in  `size`  frame to send; sampled only on the acceptance edge.
- `ready`  out  1  high in IDLE.
- `done`  out  1  one-cycle pulse after a frame completes normally.
- `sclk`  out  1  serial clock; idle level is 0.
- `mosi`  out  1  serial data, MSB first.
- `ssN`  out  1  frame select, active low.

## Operation
- FSM states: IDLE, SHIFT, HOLD.
- Internal registers:
  - `shiftReg[size-1:0]` holds the frame.
  - `bitCount` is $clog2(`size`) bits wide, counts 0..`size`-1, and never wraps mid-frame.
  - `divCount` is $clog2(`divider`) bits wide, counts 0..`divider`-1, then wraps to 0.
- IDLE:
  - Outputs: `ready`=1, `ssN`=1, `sclk`=0, `mosi`=0.
  - If `start`=1 and `clear`=0: load `shiftReg`←`dataIn`, clear both counters, go to SHIFT.
- SHIFT:
  - `ssN`=0 and `mosi`=`shiftReg[size-1]`.
  - `divCount` increments every cycle.
  - When `divCount`=`half`-1, `sclk` rises on the next edge.
  - When `divCount`=`divider`-1:
    - `divCount`←0 and `sclk`←0.
    - If `bitCount`=`size`-1, go to HOLD with `mosi`←0.
    - Otherwise shift `shiftReg` left by 1 and increment `bitCount`.
- HOLD:
  - `ssN`=0, `sclk`=0, `mosi`=0, held for `half` cycles.
  - Then go to IDLE with `done`=1 for exactly one cycle.
- `start` while `ready`=0 is ignored, with no queuing. `dataIn` changes outside the acceptance edge have no effect.
- `clear`=1 in any state:
  - Next edge: go to IDLE with idle outputs.
  - No `done` pulse; the frame is discarded.
  - `start` on the same edge is ignored.
- `reset` at any time, mid-frame included:
  - All outputs take reset values asynchronously.
  - Counters are 0 and `shiftReg` is 0.
  - No `done` pulse.
- Reset values: `ready`=1, `done`=0, `sclk`=0, `mosi`=0, `ssN`=1.

## Timing
- Call the acceptance edge E0.
- Bit k (k=0..`size`-1, with bit k = `dataIn[size-1-k]`):
  - `mosi` is valid from edge E0+k·`divider`.
  - `sclk` rises at edge E0+k·`divider`+`half`.
  - `sclk` falls at edge E0+(k+1)·`divider`.
  - `mosi` is therefore stable for `half` cycles on each side of the `sclk` rise.
- `ssN` is low from E0 until edge E0+`size`·`divider`+`half`. At that same edge `ready`=1 and `done`=1.
- Frame select duration is `size`·`divider`+`half` cycles. Defaults give 102 cycles.
- Back-to-back frames:
  - `start` held high while `done`=1 is accepted on the next edge.
  - `ssN` is high for exactly 1 cycle between frames, the minimum gap.
- Exactly `size` `sclk` rising edges occur per complete frame. No `sclk` activity occurs while `ssN`=1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Defaults, `dataIn`=25'h1A5A5A5, 1-cycle `start` -> a receiver model clocked on `sclk` rising edges collects 25'h1A5A5A5. `ssN` is low for 102 cycles, `done` pulses once, and there are 25 `sclk` rises.
- Two frames, 25'h0000001 then 25'h1FFFFFF, `start` held high -> both received intact, the `ssN` high gap is exactly 1 cycle, and there are two `done` pulses.
- `start` pulsed at bits 3 and 20 during a frame, with `dataIn` changed -> transmitted frame unchanged and `ready` stays 0 throughout.
- `clear` asserted during bit 10 -> next edge: `ssN`=1, `sclk`=0, `mosi`=0, `ready`=1, no `done`. A following frame 25'h0F0F0F0 is sent correctly.
- Async `reset` during bit 12 -> outputs reach reset values without waiting for a clock edge. After release, a new frame 25'h1555555 is sent correctly.
- `size`=8, `divider`=2, `dataIn`=8'hA5 -> `mosi` sequence 1,0,1,0,0,1,0,1, one bit per 2 cycles, `ssN` low for 17 cycles.

Source files
------------

// File: rtl/spi_frame_transmitter_if.sv
// Parallel-side bus of the SPI frame transmitter plus its serial pins.
// Handshake: a frame is accepted on a rising clock edge where start=1, ready=1 and clear=0;
// dataIn is sampled only on that edge, and start while ready=0 is dropped, never queued.
interface spi_frame_transmitter_if #(
   parameter int size = 25
);
   logic            clear;
   logic            start;
   logic [size-1:0] dataIn;
   logic            ready;
   logic            done;
   logic            sclk;
   logic            mosi;
   logic            ssN;

   modport master (
      output clear, start, dataIn,
      input  ready, done, sclk, mosi, ssN
   );

   modport slave (
      input  clear, start, dataIn,
      output ready, done, sclk, mosi, ssN
   );
endinterface

// File: rtl/spi_frame_transmitter.sv
// SPI master transmit shifter: takes one size-bit frame and shifts it out MSB first
// with sclk idling low, ssN framing the transfer and a one-cycle done afterwards.
module spi_frame_transmitter #(
   parameter int size    = 25,
   parameter int divider = 4
) (
   input  logic                   clock,
   input  logic                   reset,
   spi_frame_transmitter_if.slave bus,
   output logic [1:0]             debug_state
);

   localparam int half = divider / 2;
   localparam int BW   = $clog2(size);
   localparam int DW   = $clog2(divider);

   localparam logic [DW-1:0] HALF_M1  = DW'(half - 1);
   localparam logic [DW-1:0] DIV_M1   = DW'(divider - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(size - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t          state;
   logic [size-1:0] shiftReg;
   logic [BW-1:0]   bitCount;
   logic [DW-1:0]   divCount;

   // mosi is the MSB flop itself; shiftReg is zeroed whenever the line must idle low.
   assign bus.mosi    = shiftReg[size-1];
   assign debug_state = state;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         shiftReg  <= '0;
         bitCount  <= '0;
         divCount  <= '0;
         bus.ready <= 1'b1;
         bus.done  <= 1'b0;
         bus.sclk  <= 1'b0;
         bus.ssN   <= 1'b1;
      end else begin
         bus.done <= 1'b0;
         if (bus.clear) begin
            state     <= IDLE;
            shiftReg  <= '0;
            bitCount  <= '0;
            divCount  <= '0;
            bus.ready <= 1'b1;
            bus.sclk  <= 1'b0;
            bus.ssN   <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     state     <= SHIFT;
                     shiftReg  <= bus.dataIn;
                     bitCount  <= '0;
                     divCount  <= '0;
                     bus.ready <= 1'b0;
                     bus.ssN   <= 1'b0;
                  end
               end
               SHIFT: begin
                  divCount <= divCount + 1'b1;
                  if (divCount == HALF_M1) begin
                     bus.sclk <= 1'b1;
                  end
                  if (divCount == DIV_M1) begin
                     divCount <= '0;
                     bus.sclk <= 1'b0;
                     if (bitCount == LAST_BIT) begin
                        state    <= HOLD;
                        shiftReg <= '0;
                     end else begin
                        shiftReg <= {shiftReg[size-2:0], 1'b0};
                        bitCount <= bitCount + 1'b1;
                     end
                  end
               end
               HOLD: begin
                  // Keeps ssN low for half a bit after the last falling sclk edge.
                  divCount <= divCount + 1'b1;
                  if (divCount == HALF_M1) begin
                     state     <= IDLE;
                     divCount  <= '0;
                     bitCount  <= '0;
                     bus.ready <= 1'b1;
                     bus.ssN   <= 1'b1;
                     bus.done  <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
